// File: rtl/vliw_uart_pkg.sv
// Shared constants and types for the VLIW UART receive path.
// Latency/backpressure: none; this file holds declarations only.
package vliw_uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Start-bit confirmation point: the middle of the bit period.
  function automatic logic [15:0] half_period(input logic [15:0] div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/vliw_fifo.sv
// Synchronous circular-buffer FIFO; head shown combinationally, occupancy 0..DEPTH.
// Latency: push visible next cycle; backpressure: push while full is taken only together with a pop.
module vliw_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = CW - 1;

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    // Full when the pointers wrap to the same slot on different laps.
    full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + CW'(do_push);
    rd_ptr_d = rd_ptr_q + CW'(do_pop);
    count    = wr_ptr_q - rd_ptr_q;
    pop_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/vliw_uart_rx_fifo.sv
// 8N1 UART receiver (2-FF sync, mid-bit sampling, glitch/break rejection) feeding a small FIFO.
// Latency: byte visible one clk after its stop sample; backpressure: full FIFO drops the byte and sets overrun unless popped that cycle.
module vliw_uart_rx_fifo
  import vliw_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   divisor,
  input  logic          RX,
  output logic [7:0]    dout,
  output logic          has_byte,
  input  logic          rd,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          frame_err,
  output logic          overrun,
  input  logic          clr_err
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   rx_s;
  logic                   rx_vld;

  rx_state_e              state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            div_q, div_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   armed_q, armed_d;
  logic                   push_q, push_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic                   frame_err_set;
  logic                   overrun_set;
  logic                   fifo_full;
  logic                   fifo_empty;

  // sync_vld tracks which stages hold real line samples, so the reset
  // value of the synchronizer cannot re-arm the receiver on a held-low line.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], RX};
    sync_vld_d = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    rx_s       = sync_q[SYNC_STAGES-1];
    rx_vld     = sync_vld_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    armed_d       = armed_q;
    push_d        = 1'b0;
    frame_err_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_vld && rx_s) begin
          armed_d = 1'b1;
        end
        if (armed_q && rx_vld && !rx_s) begin
          state_d = ST_START;
          // The detection edge counts as the first START clock.
          cnt_d   = 16'd1;
          div_d   = divisor;
        end
      end

      ST_START: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == half_period(div_q)) begin
          if (rx_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end
        end
      end

      ST_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == div_q) begin
          shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == div_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (rx_s) begin
            push_d = 1'b1;
          end else begin
            frame_err_set = 1'b1;
            armed_d       = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // New error events win over a coincident clear.
  always_comb begin
    overrun_set = push_q & fifo_full & ~rd;
    frame_err_d = frame_err_set | (frame_err_q & ~clr_err);
    overrun_d   = overrun_set | (overrun_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '1;
      sync_vld_q  <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      armed_q     <= 1'b0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sync_vld_q  <= sync_vld_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      armed_q     <= armed_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  vliw_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_BITS),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_q),
    .push_dat (shreg_q),
    .pop      (rd),
    .pop_dat  (dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  always_comb begin
    has_byte  = ~fifo_empty;
    busy      = (state_q != ST_IDLE);
    frame_err = frame_err_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_vliw_uart_rx_fifo.sv
// Bench for vliw_uart_rx_fifo: serial frames driven bit by bit, results checked
// against a queue model of the receive FIFO and its sticky flags.
module tb_vliw_uart_rx_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   divisor = 16'd9;
  logic          RX = 1'b1;
  logic [7:0]    dout;
  logic          has_byte;
  logic          rd = 1'b0;
  logic [CW-1:0] count;
  logic          busy;
  logic          frame_err;
  logic          overrun;
  logic          clr_err = 1'b0;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int frame_n = 0;

  logic [7:0] q[$];
  logic       exp_ferr = 1'b0;
  logic       exp_ovr = 1'b0;

  vliw_uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .divisor   (divisor),
    .RX        (RX),
    .dout      (dout),
    .has_byte  (has_byte),
    .rd        (rd),
    .count     (count),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  // Reference: a good stop bit delivers the byte unless DEPTH bytes are waiting.
  task automatic model_rx(input logic [7:0] b, input logic stop);
    if (!stop) exp_ferr = 1'b1;
    else if (q.size() < DEPTH) q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  // Frame line levels; frame_n is the edge that first samples the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
    frame_n = cyc + 1;
    RX = 1'b0;
    hold(bclk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      hold(bclk);
    end
    RX = stop;
    hold(bclk);
    model_rx(b, stop);
  endtask

  task automatic pop_byte(output logic [7:0] got, output logic hb);
    got = dout;
    hb  = has_byte;
    rd  = 1'b1;
    tick();
    rd  = 1'b0;
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    hold(3);
    checks++;
    if ({has_byte, count, busy, frame_err, overrun, dout} !== '0)
      $display("FAIL reset_in: hb=%b cnt=%0d busy=%b fe=%b ov=%b dout=%02h, all required 0",
               has_byte, count, busy, frame_err, overrun, dout);
    else passes++;
    rst = 1'b0;
    hold(6);
    checks++;
    if ({has_byte, count, busy, frame_err, overrun, dout} !== '0)
      $display("FAIL reset_out: hb=%b cnt=%0d busy=%b fe=%b ov=%b dout=%02h, all required 0",
               has_byte, count, busy, frame_err, overrun, dout);
    else passes++;
  endtask

  task automatic test_clean_byte;
    logic [7:0] got, exp;
    logic hb;
    fork
      send_frame(8'hA5, 1'b1, 10);
      begin
        #2;
        while (cyc < frame_n + 96) @(negedge clk);
        checks++;
        if (has_byte !== 1'b0) $display("FAIL clean_early: has_byte=%b at N+96, required 0", has_byte);
        else passes++;
        @(negedge clk);
        checks++;
        if (has_byte !== 1'b1 || dout !== 8'hA5 || count !== 3'd1)
          $display("FAIL clean_at97: hb=%b dout=%02h cnt=%0d, required hb=1 dout=a5 cnt=1", has_byte, dout, count);
        else passes++;
      end
    join
    pop_byte(got, hb);
    exp = q.pop_front();
    checks++;
    if (hb !== 1'b1 || got !== exp) $display("FAIL clean_pop: hb=%b dout=%02h, required 1 %02h", hb, got, exp);
    else passes++;
    checks++;
    if (has_byte !== 1'b0 || count !== 3'd0) $display("FAIL clean_empty: hb=%b cnt=%0d, required 0 0", has_byte, count);
    else passes++;
  endtask

  task automatic test_glitch;
    logic saw_busy = 1'b0;
    RX = 1'b0;
    hold(3);
    RX = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b1) $display("FAIL glitch_busy: busy never rose, required a pulse");
    else passes++;
    checks++;
    if (busy !== 1'b0 || count !== 3'd0 || frame_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL glitch_idle: busy=%b cnt=%0d fe=%b ov=%b, required 0 0 0 0", busy, count, frame_err, overrun);
    else passes++;
  endtask

  task automatic test_framing_break;
    logic [7:0] got, exp;
    logic hb;
    fork
      send_frame(8'h3C, 1'b0, 10);
      begin
        #2;
        wait_edge(frame_n + 95);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
      end
    join
    hold(200);
    checks++;
    if (frame_err !== exp_ferr || count !== 3'(q.size()) || busy !== 1'b0)
      $display("FAIL break_hold: fe=%b cnt=%0d busy=%b, required %b %0d 0", frame_err, count, busy, exp_ferr, q.size());
    else passes++;
    RX = 1'b1;
    hold(20);
    checks++;
    if (count !== 3'd0 || busy !== 1'b0) $display("FAIL break_release: cnt=%0d busy=%b, required 0 0", count, busy);
    else passes++;
    send_frame(8'h55, 1'b1, 10);
    pop_byte(got, hb);
    exp = q.pop_front();
    checks++;
    if (hb !== 1'b1 || got !== exp) $display("FAIL break_next: hb=%b dout=%02h, required 1 %02h", hb, got, exp);
    else passes++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_ferr = 1'b0;
    checks++;
    if (frame_err !== exp_ferr) $display("FAIL break_clr: fe=%b, required %b", frame_err, exp_ferr);
    else passes++;
  endtask

  task automatic test_overrun;
    logic [7:0] got, exp;
    logic hb;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 10);
    checks++;
    if (count !== 3'(q.size()) || overrun !== exp_ovr)
      $display("FAIL ovr_state: cnt=%0d ov=%b, required %0d %b", count, overrun, q.size(), exp_ovr);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      pop_byte(got, hb);
      exp = q.pop_front();
      checks++;
      if (hb !== 1'b1 || got !== exp) $display("FAIL ovr_pop%0d: hb=%b dout=%02h, required 1 %02h", i, hb, got, exp);
      else passes++;
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_ovr = 1'b0;
    checks++;
    if (overrun !== exp_ovr || has_byte !== 1'b0) $display("FAIL ovr_clr: ov=%b hb=%b, required 0 0", overrun, has_byte);
    else passes++;
  endtask

  task automatic test_full_simul_pop;
    logic [7:0] got, exp;
    logic hb;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 10);
    checks++;
    if (count !== 3'd4) $display("FAIL full_fill: cnt=%0d, required 4", count);
    else passes++;
    fork
      send_frame(8'h14, 1'b1, 10);
      begin
        #2;
        wait_edge(frame_n + 96);
        pop_byte(got, hb);
        exp = q.pop_front();
        checks++;
        if (hb !== 1'b1 || got !== exp) $display("FAIL full_simul_pop: hb=%b dout=%02h, required 1 %02h", hb, got, exp);
        else passes++;
      end
    join
    checks++;
    if (overrun !== exp_ovr || count !== 3'(q.size()))
      $display("FAIL full_after: ov=%b cnt=%0d, required %b %0d", overrun, count, exp_ovr, q.size());
    else passes++;
    while (q.size() != 0) begin
      pop_byte(got, hb);
      exp = q.pop_front();
      checks++;
      if (hb !== 1'b1 || got !== exp) $display("FAIL full_order: hb=%b dout=%02h, required 1 %02h", hb, got, exp);
      else passes++;
    end
  endtask

  task automatic test_divisor_change;
    logic [7:0] got, exp, b;
    logic hb;
    fork
      send_frame(8'h81, 1'b1, 10);
      begin
        #2;
        wait_edge(frame_n + 40);
        divisor = 16'd19;
      end
    join
    pop_byte(got, hb);
    exp = q.pop_front();
    checks++;
    if (hb !== 1'b1 || got !== exp) $display("FAIL div_mid: hb=%b dout=%02h, required 1 %02h", hb, got, exp);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 20);
      pop_byte(got, hb);
      exp = q.pop_front();
      checks++;
      if (hb !== 1'b1 || got !== exp) $display("FAIL div_20clk%0d: hb=%b dout=%02h, required 1 %02h", i, hb, got, exp);
      else passes++;
    end
    divisor = 16'd9;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] got, exp, b;
    logic hb;
    send_frame(8'h66, 1'b1, 10);
    fork
      send_frame(8'hF0, 1'b1, 10);
      begin
        #2;
        wait_edge(frame_n + 15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        checks++;
        if ({has_byte, count, busy, frame_err, overrun, dout} !== '0)
          $display("FAIL rst_mid: hb=%b cnt=%0d busy=%b fe=%b ov=%b dout=%02h, all required 0",
                   has_byte, count, busy, frame_err, overrun, dout);
        else passes++;
      end
    join
    q.delete();
    hold(20);
    checks++;
    if (busy !== 1'b0 || count !== 3'd0 || frame_err !== 1'b0)
      $display("FAIL rst_partial: busy=%b cnt=%0d fe=%b, required 0 0 0", busy, count, frame_err);
    else passes++;
    b = 8'($urandom);
    send_frame(b, 1'b1, 10);
    pop_byte(got, hb);
    exp = q.pop_front();
    checks++;
    if (hb !== 1'b1 || got !== exp) $display("FAIL rst_recover: hb=%b dout=%02h, required 1 %02h", hb, got, exp);
    else passes++;
  endtask

  task automatic test_random;
    logic [7:0] got, exp, b;
    logic hb, stop;
    for (int it = 0; it < 12; it++) begin
      divisor = 16'($urandom_range(15, 3));
      b       = 8'($urandom);
      stop    = ($urandom_range(5, 0) != 0);
      send_frame(b, stop, int'(divisor) + 1);
      if (!stop) begin
        RX = 1'b1;
        hold(6);
      end
      checks++;
      if (count !== 3'(q.size()) || frame_err !== exp_ferr || overrun !== exp_ovr)
        $display("FAIL rand_state%0d: cnt=%0d fe=%b ov=%b, required %0d %b %b",
                 it, count, frame_err, overrun, q.size(), exp_ferr, exp_ovr);
      else passes++;
      if (q.size() != 0 && $urandom_range(1, 0) == 1) begin
        pop_byte(got, hb);
        exp = q.pop_front();
        checks++;
        if (hb !== 1'b1 || got !== exp) $display("FAIL rand_pop%0d: hb=%b dout=%02h, required 1 %02h", it, hb, got, exp);
        else passes++;
      end
    end
    while (q.size() != 0) begin
      pop_byte(got, hb);
      exp = q.pop_front();
      checks++;
      if (hb !== 1'b1 || got !== exp) $display("FAIL rand_drain: hb=%b dout=%02h, required 1 %02h", hb, got, exp);
      else passes++;
    end
    checks++;
    if (has_byte !== 1'b0) $display("FAIL rand_empty: hb=%b, required 0", has_byte);
    else passes++;
    divisor = 16'd9;
  endtask

  initial begin
    test_reset();
    test_clean_byte();
    test_glitch();
    test_framing_break();
    test_overrun();
    test_full_simul_pop();
    test_divisor_change();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
